wbank_ctrl: RTL

WBANK_CTRL -- requirements
Module: wbank_ctrl

---
 rtl/wbank_ctrl_pkg.sv | 21 ++
 rtl/wbank_ctrl_if.sv | 54 +++++
 rtl/wbank_status.sv | 58 +++++
 rtl/wbank_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/wbank_ctrl_pkg.sv
// Shared types and helpers for the write-bank rotation controller.
// Holds the FSM encoding, bank count, bank-index width and the bank wrap function.
package wbank_ctrl_pkg;

  localparam int BANK_NUM = 3;
  localparam int BIDX_W   = 2;

  typedef logic [BIDX_W-1:0] bidx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Banks rotate 0 -> 1 -> ... -> BANK_NUM-1 -> 0.
  function automatic bidx_t next_bank(input bidx_t b);
    return (b == bidx_t'(BANK_NUM - 1)) ? '0 : b + bidx_t'(1);
  endfunction

endpackage

// File: rtl/wbank_ctrl_if.sv
// Interfaces of the write-bank controller: the external producer/reader bus
// bundle and the internal link between the write FSM and the bank-status block.

// Producer handshake: a beat transfers on a rising edge where data_vld & wready
// are both high; wready is a registered state decode and never looks at data_vld.
interface wbank_bus_if #(
  parameter int AW       = 10,
  parameter int BANK_NUM = 3
);
  logic                data_sop;
  logic                data_vld;
  logic [AW:0]         bank_len;
  logic                rbank_done;
  logic                wready;
  logic                wbank_update;
  logic [1:0]          wbank_sel;
  logic [1:0]          rbank_sel;
  logic                rd_valid;
  logic [BANK_NUM-1:0] bank_full;
  logic                err;

  modport master (
    output data_sop, data_vld, bank_len, rbank_done,
    input  wready, wbank_update, wbank_sel, rbank_sel, rd_valid, bank_full, err
  );

  modport slave (
    input  data_sop, data_vld, bank_len, rbank_done,
    output wready, wbank_update, wbank_sel, rbank_sel, rd_valid, bank_full, err
  );
endinterface

interface wbank_stat_if #(
  parameter int BANK_NUM = 3
);
  logic                  clr_all;
  logic                  set_en;
  wbank_ctrl_pkg::bidx_t set_idx;
  logic                  rbank_done;
  logic [BANK_NUM-1:0]   full;
  wbank_ctrl_pkg::bidx_t rbank_sel;
  logic                  rd_valid;
  logic                  err;

  modport ctrl (
    output clr_all, set_en, set_idx, rbank_done,
    input  full, rbank_sel, rd_valid, err
  );

  modport status (
    input  clr_all, set_en, set_idx, rbank_done,
    output full, rbank_sel, rd_valid, err
  );
endinterface

// File: rtl/wbank_status.sv
// Bank occupancy tracker: per-bank full flags, read-bank pointer and the
// sticky error raised when the reader releases a bank that holds no fill.
module wbank_status #(
  parameter int BANK_NUM = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  wbank_stat_if.status st
);
  import wbank_ctrl_pkg::*;

  logic [BANK_NUM-1:0] full_q, full_d;
  bidx_t               rsel_q, rsel_d;
  logic                err_q,  err_d;

  // A set and a clear in the same cycle never hit the same bank: the writer
  // only fills an empty bank and the reader only releases a full one.
  always_comb begin
    full_d = full_q;
    rsel_d = rsel_q;
    err_d  = err_q;
    if (st.clr_all) begin
      full_d = '0;
      rsel_d = '0;
      err_d  = 1'b0;
    end else begin
      if (st.set_en) begin
        full_d[st.set_idx] = 1'b1;
      end
      if (st.rbank_done) begin
        if (full_q[rsel_q]) begin
          full_d[rsel_q] = 1'b0;
          rsel_d         = next_bank(rsel_q);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      rsel_q <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      rsel_q <= rsel_d;
      err_q  <= err_d;
    end
  end

  assign st.full      = full_q;
  assign st.rbank_sel = rsel_q;
  assign st.rd_valid  = full_q[rsel_q];
  assign st.err       = err_q;

endmodule

// File: rtl/wbank_ctrl.sv
// Write-side controller for a rotating set of SRAM banks: counts producer beats,
// hands completed banks to the reader and stalls when the next bank is still full.
module wbank_ctrl #(
  parameter int AW       = 10,
  parameter int BANK_NUM = 3
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                DATA_SOP,
  input  logic                DATA_VLD,
  input  logic [AW:0]         BANK_LEN,
  input  logic                RBANK_DONE,
  output logic                WREADY,
  output logic                WBANK_UPDATE,
  output logic [1:0]          WBANK_SEL,
  output logic [1:0]          RBANK_SEL,
  output logic                RD_VALID,
  output logic [BANK_NUM-1:0] BANK_FULL,
  output logic                ERR
);
  import wbank_ctrl_pkg::*;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic [AW:0] wcnt_q,  wcnt_d;
  logic [AW:0] len_q,   len_d;
  bidx_t       wsel_q,  wsel_d;
  logic        upd_q,   upd_d;

  logic        accept;
  logic        last_beat;
  logic        set_en;
  bidx_t       nxt;
  logic        clr_next;
  logic        clr_cur;

  wbank_stat_if #(.BANK_NUM(BANK_NUM)) st_if ();

  wbank_status #(.BANK_NUM(BANK_NUM)) u_status (
    .clk   (SYS_CLK),
    .rst_n (SYS_RST),
    .st    (st_if)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    wsel_d    = wsel_q;
    upd_d     = 1'b0;
    set_en    = 1'b0;
    accept    = (state_q == ST_RUN) && DATA_VLD;
    last_beat = accept && (wcnt_q == len_q - ONE);
    nxt       = next_bank(wsel_q);
    // A release landing on the same edge counts as the bank already being free.
    clr_next  = RBANK_DONE && st_if.full[st_if.rbank_sel] && (st_if.rbank_sel == nxt);
    clr_cur   = RBANK_DONE && st_if.full[st_if.rbank_sel] && (st_if.rbank_sel == wsel_q);
    if (DATA_SOP) begin
      state_d = ST_RUN;
      wcnt_d  = '0;
      wsel_d  = '0;
      len_d   = (BANK_LEN == '0) ? ONE : BANK_LEN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (last_beat) begin
            wcnt_d = '0;
            wsel_d = nxt;
            upd_d  = 1'b1;
            set_en = 1'b1;
            if (st_if.full[nxt] && !clr_next) begin
              state_d = ST_STALL;
            end
          end else if (accept) begin
            wcnt_d = wcnt_q + ONE;
          end
        end
        ST_STALL: begin
          if (clr_cur) begin
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      len_q   <= ONE;
      wsel_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      wsel_q  <= wsel_d;
      upd_q   <= upd_d;
    end
  end

  assign st_if.clr_all    = DATA_SOP;
  assign st_if.set_en     = set_en;
  assign st_if.set_idx    = wsel_q;
  assign st_if.rbank_done = RBANK_DONE;

  assign WREADY       = (state_q == ST_RUN);
  assign WBANK_UPDATE = upd_q;
  assign WBANK_SEL    = wsel_q;
  assign RBANK_SEL    = st_if.rbank_sel;
  assign RD_VALID     = st_if.rd_valid;
  assign BANK_FULL    = st_if.full;
  assign ERR          = st_if.err;

endmodule
